inst_dispatch_ctrl: RTL and testbench

In-order instruction buffer and dispatch sequencer placed between fetch and the decoder.
- Queues fetched {inst, PC, NPC} triples.
- Presents the head entry to the decoder and pops it only when the downstream RS/ROB can accept.
- Stops dispatch after a halt (WFI) or illegal instruction until a squash.
- Squash from a branch mispredict empties the queue in one cycle.

---
 rtl/inst_dispatch_ctrl.sv | 127 ++++++++++++
 tb/tb_inst_dispatch_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_dispatch_ctrl.sv
// In-order instruction buffer between fetch and decode.
// Holds fetched {inst, PC, NPC} triples in a circular queue and presents the
// head entry to the decoder. A dispatched halt or illegal instruction stops
// dispatch until a squash, and the squash empties the queue in one cycle.
module inst_dispatch_ctrl #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       if_valid,
    input  logic [XLEN-1:0]            if_inst,
    input  logic [XLEN-1:0]            if_PC,
    input  logic [XLEN-1:0]            if_NPC,
    output logic                       if_ready,
    input  logic                       squash,
    input  logic                       dispatch_ready,
    output logic                       dec_valid,
    output logic [XLEN-1:0]            dec_inst,
    output logic [XLEN-1:0]            dec_PC,
    output logic [XLEN-1:0]            dec_NPC,
    input  logic                       dec_is_halt,
    input  logic                       dec_is_illegal,
    output logic                       dispatch_fire,
    output logic                       halted,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h00000013);

    typedef enum logic {
        RUN     = 1'b0,
        STOPPED = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] npc_mem  [DEPTH];
    logic            enq;
    logic            deq;
    logic            stop;
    logic            not_empty;

    // Handshake qualifiers; a full queue never accepts, even if the head leaves this cycle.
    always_comb begin
        not_empty     = (count != '0);
        if_ready      = (state == RUN) && (count < CW'(DEPTH));
        dec_valid     = (state == RUN) && not_empty;
        dispatch_fire = dec_valid && dispatch_ready && !squash;
        enq           = if_valid && if_ready && !squash;
        deq           = dispatch_fire;
        stop          = dispatch_fire && (dec_is_halt || dec_is_illegal);
        halted        = (state == STOPPED);
    end

    // Decoder sees the head entry, or a NOP with zero PCs while the queue is empty.
    always_comb begin
        dec_inst = NOP;
        dec_PC   = '0;
        dec_NPC  = '0;
        if (not_empty) begin
            dec_inst = inst_mem[head];
            dec_PC   = pc_mem[head];
            dec_NPC  = npc_mem[head];
        end
    end

    // Next state: squash always returns to RUN, a halting dispatch parks in STOPPED.
    always_comb begin
        state_next = state;
        if (squash) begin
            state_next = RUN;
        end else if (stop) begin
            state_next = STOPPED;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Pointers and occupancy; squash or a halting dispatch empties everything at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (squash || stop) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            if (enq && !deq) begin
                count <= count + 1'b1;
            end else if (!enq && deq) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge clock) begin
        if (enq && !stop) begin
            inst_mem[tail] <= if_inst;
            pc_mem[tail]   <= if_PC;
            npc_mem[tail]  <= if_NPC;
        end
    end

endmodule

// File: tb/tb_inst_dispatch_ctrl.sv
// Self-checking bench for inst_dispatch_ctrl: a queue-based reference model
// predicts every output each cycle; directed sequences pin the model to
// hand-computed values, then randomized traffic runs against it.
module tb_inst_dispatch_ctrl;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int CW    = $clog2(DEPTH+1);
    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] WFI = 32'h10500073;
    localparam logic [31:0] ADD = 32'h00208033;

    logic            clock;
    logic            reset;
    logic            if_valid;
    logic [XLEN-1:0] if_inst;
    logic [XLEN-1:0] if_PC;
    logic [XLEN-1:0] if_NPC;
    logic            if_ready;
    logic            squash;
    logic            dispatch_ready;
    logic            dec_valid;
    logic [XLEN-1:0] dec_inst;
    logic [XLEN-1:0] dec_PC;
    logic [XLEN-1:0] dec_NPC;
    logic            dec_is_halt;
    logic            dec_is_illegal;
    logic            dispatch_fire;
    logic            halted;
    logic [CW-1:0]   count;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } entry_t;

    entry_t model_q [$];
    logic   model_stopped;
    int     checks;
    int     failures;

    inst_dispatch_ctrl #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clock          (clock),
        .reset          (reset),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_PC          (if_PC),
        .if_NPC         (if_NPC),
        .if_ready       (if_ready),
        .squash         (squash),
        .dispatch_ready (dispatch_ready),
        .dec_valid      (dec_valid),
        .dec_inst       (dec_inst),
        .dec_PC         (dec_PC),
        .dec_NPC        (dec_NPC),
        .dec_is_halt    (dec_is_halt),
        .dec_is_illegal (dec_is_illegal),
        .dispatch_fire  (dispatch_fire),
        .halted         (halted),
        .count          (count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [31:0] npc, input logic sq, input logic dr,
                                 input logic hl, input logic il);
        @(negedge clock);
        if_valid       = v;
        if_inst        = inst;
        if_PC          = pc;
        if_NPC         = npc;
        squash         = sq;
        dispatch_ready = dr;
        dec_is_halt    = hl;
        dec_is_illegal = il;
        #1;
    endtask

    task automatic idleStimulus(input logic dr, input logic sq);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, sq, dr, 1'b0, 1'b0);
    endtask

    // Model predictions from the queue contents and the current inputs.
    function automatic logic expReady();
        return !model_stopped && (model_q.size() < DEPTH);
    endfunction

    function automatic logic expValid();
        return !model_stopped && (model_q.size() != 0);
    endfunction

    function automatic logic expFire();
        return expValid() && dispatch_ready && !squash;
    endfunction

    // Compare every DUT output against the model for this cycle.
    task automatic checkOutput();
        entry_t h;
        h.inst = NOP;
        h.pc   = 32'h0;
        h.npc  = 32'h0;
        if (model_q.size() != 0) h = model_q[0];
        checkEq("if_ready",      32'(if_ready),      32'(expReady()));
        checkEq("dec_valid",     32'(dec_valid),     32'(expValid()));
        checkEq("dispatch_fire", 32'(dispatch_fire), 32'(expFire()));
        checkEq("halted",        32'(halted),        32'(model_stopped));
        checkEq("count",         32'(count),         32'(model_q.size()));
        checkEq("dec_inst",      dec_inst,           h.inst);
        checkEq("dec_PC",        dec_PC,             h.pc);
        checkEq("dec_NPC",       dec_NPC,            h.npc);
    endtask

    // Advance past the rising edge and apply the same rules to the model.
    task automatic advance();
        logic   rdy;
        logic   fire;
        entry_t e;
        rdy  = expReady();
        fire = expFire();
        @(posedge clock);
        if (squash) begin
            model_q.delete();
            model_stopped = 1'b0;
        end else if (fire && (dec_is_halt || dec_is_illegal)) begin
            model_q.delete();
            model_stopped = 1'b1;
        end else begin
            if (fire) void'(model_q.pop_front());
            if (if_valid && rdy) begin
                e.inst = if_inst;
                e.pc   = if_PC;
                e.npc  = if_NPC;
                model_q.push_back(e);
            end
        end
    endtask

    task automatic enqueueOne(input logic [31:0] inst, input logic [31:0] pc);
        applyStimulus(1'b1, inst, pc, pc + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();
        advance();
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        model_stopped  = 1'b0;
        reset          = 1'b1;
        if_valid       = 1'b0;
        if_inst        = '0;
        if_PC          = '0;
        if_NPC         = '0;
        squash         = 1'b0;
        dispatch_ready = 1'b0;
        dec_is_halt    = 1'b0;
        dec_is_illegal = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Reset state.
        idleStimulus(1'b0, 1'b0);
        checkOutput();
        checkEq("rst_dec_inst", dec_inst, NOP);
        checkEq("rst_if_ready", 32'(if_ready), 32'd1);
        advance();

        // Single ADDI, held, then dispatched.
        applyStimulus(1'b1, 32'h00500093, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();
        checkEq("nobypass_dec_valid", 32'(dec_valid), 32'd0);
        advance();
        idleStimulus(1'b0, 1'b0);
        checkOutput();
        checkEq("addi_dec_inst", dec_inst, 32'h00500093);
        checkEq("addi_count", 32'(count), 32'd1);
        checkEq("addi_hold_fire", 32'(dispatch_fire), 32'd0);
        advance();
        idleStimulus(1'b1, 1'b0);
        checkOutput();
        checkEq("addi_fire", 32'(dispatch_fire), 32'd1);
        advance();
        idleStimulus(1'b0, 1'b0);
        checkOutput();
        checkEq("addi_empty_count", 32'(count), 32'd0);
        checkEq("addi_empty_inst", dec_inst, NOP);
        advance();

        // Fill to DEPTH, drop a ninth offer, drain in order.
        for (int i = 0; i < DEPTH; i++) enqueueOne(ADD + 32'(i << 7), 32'(i * 4));
        applyStimulus(1'b1, 32'hDEADBEEF, 32'h20, 32'h24, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput();
        checkEq("full_count", 32'(count), 32'd8);
        checkEq("full_if_ready", 32'(if_ready), 32'd0);
        advance();
        for (int i = 0; i < DEPTH; i++) begin
            idleStimulus(1'b1, 1'b0);
            checkOutput();
            checkEq("drain_pc", dec_PC, 32'(i * 4));
            advance();
        end
        idleStimulus(1'b0, 1'b0);
        checkOutput();
        checkEq("drain_count", 32'(count), 32'd0);
        advance();

        // Continuous enqueue and dispatch; pointers wrap twice.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, ADD, 32'h200 + 32'(k * 4), 32'h204 + 32'(k * 4),
                          1'b0, 1'b1, 1'b0, 1'b0);
            checkOutput();
            if (k > 0) begin
                checkEq("stream_count", 32'(count), 32'd1);
                checkEq("stream_pc", dec_PC, 32'h200 + 32'((k - 1) * 4));
            end
            advance();
        end
        idleStimulus(1'b1, 1'b0);
        checkOutput();
        advance();

        // ADD, WFI, ADD: halting on the WFI stops dispatch until squash.
        enqueueOne(ADD, 32'h100);
        enqueueOne(WFI, 32'h104);
        enqueueOne(ADD, 32'h108);
        idleStimulus(1'b1, 1'b0);
        checkOutput();
        advance();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput();
        checkEq("wfi_fire", 32'(dispatch_fire), 32'd1);
        checkEq("wfi_inst", dec_inst, WFI);
        advance();
        applyStimulus(1'b1, ADD, 32'h10C, 32'h110, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput();
        checkEq("stop_halted", 32'(halted), 32'd1);
        checkEq("stop_count", 32'(count), 32'd0);
        checkEq("stop_if_ready", 32'(if_ready), 32'd0);
        checkEq("stop_dec_valid", 32'(dec_valid), 32'd0);
        advance();
        idleStimulus(1'b0, 1'b1);
        checkOutput();
        advance();
        idleStimulus(1'b0, 1'b0);
        checkOutput();
        checkEq("resume_halted", 32'(halted), 32'd0);
        checkEq("resume_if_ready", 32'(if_ready), 32'd1);
        advance();

        // Squash wins over a same-cycle enqueue and dispatch.
        for (int i = 0; i < 5; i++) enqueueOne(ADD, 32'h300 + 32'(i * 4));
        applyStimulus(1'b1, 32'hCAFEF00D, 32'h400, 32'h404, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput();
        checkEq("squash_fire", 32'(dispatch_fire), 32'd0);
        advance();
        idleStimulus(1'b0, 1'b0);
        checkOutput();
        checkEq("squash_count", 32'(count), 32'd0);
        checkEq("squash_dec_valid", 32'(dec_valid), 32'd0);
        advance();

        // Asynchronous reset mid-stream with three entries queued.
        for (int i = 0; i < 3; i++) enqueueOne(ADD, 32'h500 + 32'(i * 4));
        @(negedge clock);
        if_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkEq("async_count", 32'(count), 32'd0);
        checkEq("async_dec_valid", 32'(dec_valid), 32'd0);
        checkEq("async_halted", 32'(halted), 32'd0);
        model_q.delete();
        model_stopped = 1'b0;
        #1;
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(9) < 7), $urandom, $urandom, $urandom,
                          ($urandom_range(39) == 0), ($urandom_range(9) < 6),
                          ($urandom_range(29) == 0), ($urandom_range(49) == 0));
            checkOutput();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
